wave_mem_arbiter: RTL and testbench
===================================

Name: wave_mem_arbiter

Overview:
- Shares one synchronous waveform sample RAM read port between the two DDS channels (CH1, CH2).
- Each channel's phase accumulator issues sample reads on its own WaveformClock tick. The arbiter grants one read per cycle, round-robin, and steers returned data back to the owning channel.
- Each channel's output register feeds its 12-bit DAC bus and holds the last sample between reads.

Parameters:
- ADDR_W, 10, waveform RAM address width (samples per table = 2^ADDR_W).
- DATA_W, 12, sample width; matches DAC bus width.
- RAM_LAT, 1, RAM read latency in cycles from mem_en_o to mem_data_i valid; legal values 1..3.

Ports:
- sys_clk_i  in  1  system clock; all logic on rising edge.
- sys_rst_i  in  1  asynchronous reset, active-low.
- arb_en_i  in  1  global enable; low = no new grants, in-flight reads still complete.
- ch1_req_i  in  1  CH1 read request; held high until granted.
- ch1_addr_i  in  ADDR_W  CH1 sample address; stable while ch1_req_i is high.
- ch1_gnt_o  out  1  CH1 grant (combinational); accept = ch1_req_i & ch1_gnt_o at a clock edge.
- ch1_data_o  out  DATA_W  CH1 sample; registered, holds value between updates.
- ch1_vld_o  out  1  one-cycle pulse; ch1_data_o updated this cycle.
- ch2_req_i, ch2_addr_i, ch2_gnt_o, ch2_data_o, ch2_vld_o: same as the CH1 ports, for CH2.
- mem_en_o  out  1  RAM read enable; registered.
- mem_addr_o  out  ADDR_W  RAM read address; registered.
- mem_data_i  in  DATA_W  RAM read data, valid RAM_LAT cycles after mem_en_o.

Behaviour:
- Reset (sys_rst_i low, asynchronous):
  - All outputs 0: gnt, vld, data, mem_en_o, mem_addr_o.
  - Last-served pointer = CH2, so CH1 wins the first tie.
  - Tag pipeline cleared; in-flight reads are discarded and produce no vld after reset release.
- Grant logic (combinational):
  - arb_en_i = 0: both gnt low.
  - Only one req high: that channel granted.
  - Both req high: channel not last served is granted.
  - At most one gnt high per cycle; gnt is never high without its req.
- Acceptance at edge T (req & gnt):
  - Last-served pointer updated to the accepted channel.
  - Cycle T+1: mem_en_o = 1, mem_addr_o = accepted address; a 1-bit owner tag enters a RAM_LAT-deep shift pipeline (tag valid + channel id).
- No acceptance: mem_en_o = 0 next cycle; mem_addr_o holds its previous value.
- Return path:
  - When a tag exits the pipeline, mem_data_i is registered into the owner's data_o.
  - Owner's vld_o pulses high for exactly one cycle.
  - Fixed latency: accept at edge T → vld_o high in cycle T+2+RAM_LAT (RAM_LAT=1: 3 cycles).
- Throughput:
  - One read per cycle total.
  - A single persistent requester is granted every cycle (back-to-back, no bubble).
  - Two persistent requesters alternate strictly CH1, CH2, CH1, …
- Ordering: per-channel returns are in request order; the fixed pipeline means no reordering.
- arb_en_i falling mid-stream:
  - Grants stop the same cycle.
  - Already accepted reads still deliver vld.
  - Pointer is unchanged while disabled.
- Simultaneous vld on both channels is impossible; at most one vld per cycle.
- Address wrap is the requester's concern; mem_addr_o passes the value through unchanged.

Optional Feature:
- Macro: WAVE_ARB_FIXED_PRIO_EN.
- Defined: CH1 has absolute priority. On a tie CH1 is always granted, the last-served pointer is unused, and CH2 can starve.
- Undefined (default): round-robin as above.

Test Plan:
- Reset release, both req high with ch1_addr=0x005, ch2_addr=0x3FF, held for 4 cycles → grants CH1, CH2, CH1, CH2; mem_addr_o sequence 0x005, 0x3FF, 0x005, 0x3FF; ch1_vld_o first high 3 cycles after first accept (RAM_LAT=1).
- Only CH2 req held 5 cycles, RAM returns mem_addr+1 → ch2_gnt_o high all 5 cycles; 5 consecutive ch2_vld_o pulses; ch1_vld_o never high; ch1_data_o stays 0.
- CH1 single read, data 0xABC → ch1_data_o = 0xABC after its vld pulse and holds 0xABC for 10+ idle cycles.
- arb_en_i low with both req high → no gnt, no mem_en_o; raise arb_en_i → first grant goes to the channel not last served.
- Assert sys_rst_i low one cycle after an accept → no vld emerges; all outputs 0; first post-reset tie grants CH1.
- Build with WAVE_ARB_FIXED_PRIO_EN and both req held 4 cycles → all 4 grants to CH1; ch2_gnt_o stays 0.

Source files
------------

// File: rtl/wave_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wave_mem_arbiter_if
// Brief    : Bundles the channel request, grant, return and RAM read-port
//            signals of the waveform memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface wave_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
);
  logic              arb_en_i;

  logic              ch1_req_i;
  logic [ADDR_W-1:0] ch1_addr_i;
  logic              ch1_gnt_o;
  logic [DATA_W-1:0] ch1_data_o;
  logic              ch1_vld_o;

  logic              ch2_req_i;
  logic [ADDR_W-1:0] ch2_addr_i;
  logic              ch2_gnt_o;
  logic [DATA_W-1:0] ch2_data_o;
  logic              ch2_vld_o;

  logic              mem_en_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_i;

  // Arbiter side
  modport slave (
    input  arb_en_i,
    input  ch1_req_i, ch1_addr_i,
    output ch1_gnt_o, ch1_data_o, ch1_vld_o,
    input  ch2_req_i, ch2_addr_i,
    output ch2_gnt_o, ch2_data_o, ch2_vld_o,
    output mem_en_o, mem_addr_o,
    input  mem_data_i
  );

  // Requester / RAM side
  modport master (
    output arb_en_i,
    output ch1_req_i, ch1_addr_i,
    input  ch1_gnt_o, ch1_data_o, ch1_vld_o,
    output ch2_req_i, ch2_addr_i,
    input  ch2_gnt_o, ch2_data_o, ch2_vld_o,
    input  mem_en_o, mem_addr_o,
    output mem_data_i
  );
endinterface
`default_nettype wire

// File: rtl/wave_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wave_mem_arbiter
// Brief    : Shares one synchronous waveform RAM read port between two DDS
//            channels. One grant per cycle (round-robin on ties), an owner
//            tag follows each read through the RAM latency and steers the
//            returned sample into the owning channel's output register.
// Options  : WAVE_ARB_FIXED_PRIO_EN - CH1 always wins ties (CH2 may starve).
// Revision : 1.0 - initial release
// ============================================================================
module wave_mem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 12,
  parameter int RAM_LAT = 1    // legal range 1..3
) (
  input logic               sys_clk_i,
  input logic               sys_rst_i,
  wave_mem_arbiter_if.slave bus
);

  localparam logic c_CH1 = 1'b0;
  localparam logic c_CH2 = 1'b1;

  logic              w_gnt1;
  logic              w_gnt2;
  logic              w_acc;
  logic [ADDR_W-1:0] w_acc_addr;

  logic              r_mem_en;
  logic [ADDR_W-1:0] r_mem_addr;

  // Stage 0 lines up with mem_en_o; stage RAM_LAT lines up with valid RAM data.
  logic [RAM_LAT:0]  r_tag_vld;
  logic [RAM_LAT:0]  r_tag_ch;
  logic              w_ret_vld;
  logic              w_ret_ch;

  logic [DATA_W-1:0] r_ch1_data;
  logic [DATA_W-1:0] r_ch2_data;
  logic              r_ch1_vld;
  logic              r_ch2_vld;

`ifdef WAVE_ARB_FIXED_PRIO_EN
  // Fixed priority grant: CH1 wins whenever it asks; gated off during reset.
  always_comb begin
    w_gnt1 = 1'b0;
    w_gnt2 = 1'b0;
    if (sys_rst_i && bus.arb_en_i) begin
      w_gnt1 = bus.ch1_req_i;
      w_gnt2 = bus.ch2_req_i & ~bus.ch1_req_i;
    end
  end
`else
  logic r_last;  // channel served by the most recent accepted read

  // Round-robin grant: on a tie the channel not served last wins.
  always_comb begin
    w_gnt1 = 1'b0;
    w_gnt2 = 1'b0;
    if (sys_rst_i && bus.arb_en_i) begin
      if (bus.ch1_req_i && bus.ch2_req_i) begin
        w_gnt1 = (r_last == c_CH2);
        w_gnt2 = (r_last == c_CH1);
      end else begin
        w_gnt1 = bus.ch1_req_i;
        w_gnt2 = bus.ch2_req_i;
      end
    end
  end

  // Last-served pointer moves only on an accepted read; reset favours CH1.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_last <= c_CH2;
    end else if (w_acc) begin
      r_last <= w_gnt2 ? c_CH2 : c_CH1;
    end
  end
`endif

  // A grant is only ever raised alongside its request, so a grant is an accept.
  assign w_acc      = w_gnt1 | w_gnt2;
  assign w_acc_addr = w_gnt2 ? bus.ch2_addr_i : bus.ch1_addr_i;

  // RAM read port: enable pulses per accept, address holds when idle.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_mem_en   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_mem_en <= w_acc;
      if (w_acc) begin
        r_mem_addr <= w_acc_addr;
      end
    end
  end

  // Owner tag pipeline; fixed depth keeps returns in request order.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_tag_vld <= '0;
      r_tag_ch  <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[RAM_LAT-1:0], w_acc};
      r_tag_ch  <= {r_tag_ch[RAM_LAT-1:0], w_gnt2};
    end
  end

  assign w_ret_vld = r_tag_vld[RAM_LAT];
  assign w_ret_ch  = r_tag_ch[RAM_LAT];

  // Steer returned sample to its owner; data holds until the next return.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_ch1_data <= '0;
      r_ch2_data <= '0;
      r_ch1_vld  <= 1'b0;
      r_ch2_vld  <= 1'b0;
    end else begin
      r_ch1_vld <= w_ret_vld & (w_ret_ch == c_CH1);
      r_ch2_vld <= w_ret_vld & (w_ret_ch == c_CH2);
      if (w_ret_vld && (w_ret_ch == c_CH1)) begin
        r_ch1_data <= bus.mem_data_i;
      end
      if (w_ret_vld && (w_ret_ch == c_CH2)) begin
        r_ch2_data <= bus.mem_data_i;
      end
    end
  end

  assign bus.ch1_gnt_o  = w_gnt1;
  assign bus.ch2_gnt_o  = w_gnt2;
  assign bus.ch1_data_o = r_ch1_data;
  assign bus.ch2_data_o = r_ch2_data;
  assign bus.ch1_vld_o  = r_ch1_vld;
  assign bus.ch2_vld_o  = r_ch2_vld;
  assign bus.mem_en_o   = r_mem_en;
  assign bus.mem_addr_o = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_wave_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_mem_arbiter
// Brief    : Scoreboard bench for wave_mem_arbiter: directed scenarios then
//            randomized requesters, checked against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wave_mem_arbiter;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 12;
  localparam int RAM_LAT = 1;
  localparam int LAT     = 2 + RAM_LAT;  // decision cycle to vld cycle

  logic sys_clk_i = 1'b0;
  logic sys_rst_i = 1'b0;
  int   cyc       = 0;
  int   checks    = 0;
  int   errors    = 0;

  wave_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  wave_mem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RAM_LAT(RAM_LAT)
  ) dut (
    .sys_clk_i(sys_clk_i),
    .sys_rst_i(sys_rst_i),
    .bus      (bus)
  );

  always #5 sys_clk_i = ~sys_clk_i;
  always @(posedge sys_clk_i) cyc <= cyc + 1;

  // Synchronous RAM with RAM_LAT cycles of read latency
  logic [DATA_W-1:0] ram     [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_pipe [0:RAM_LAT-1];

  always @(posedge sys_clk_i) begin
    for (int i = RAM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= bus.mem_en_o ? ram[bus.mem_addr_o] : 12'hF0F;
  end
  assign bus.mem_data_i = rd_pipe[RAM_LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected returns
  typedef struct {
    bit                ch;    // 0 = CH1, 1 = CH2
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  exp_t              sb_q[$];
  bit                m_last     = 1'b1;  // 1 = CH2 served last
  bit                m_prev_acc = 1'b0;
  logic [ADDR_W-1:0] m_prev_addr = '0;

  // Reference model: decide grants, check RAM port, push expected returns
  always @(negedge sys_clk_i) begin : p_model
    bit e1, e2;
    if (!sys_rst_i) begin
      m_last      = 1'b1;
      m_prev_acc  = 1'b0;
      m_prev_addr = '0;
      sb_q.delete();
    end else begin
      e1 = 1'b0;
      e2 = 1'b0;
      if (bus.arb_en_i) begin
`ifdef WAVE_ARB_FIXED_PRIO_EN
        e1 = bus.ch1_req_i;
        e2 = bus.ch2_req_i && !bus.ch1_req_i;
`else
        if (bus.ch1_req_i && bus.ch2_req_i) begin
          e1 = m_last;
          e2 = !m_last;
        end else begin
          e1 = bus.ch1_req_i;
          e2 = bus.ch2_req_i;
        end
`endif
      end
      check("grant", {bus.ch1_gnt_o, bus.ch2_gnt_o}, {e1, e2});
      check("mem_en", bus.mem_en_o, m_prev_acc);
      check("mem_addr", bus.mem_addr_o, m_prev_addr);
      m_prev_acc = e1 | e2;
      if (e1 | e2) begin
        m_prev_addr = e1 ? bus.ch1_addr_i : bus.ch2_addr_i;
        sb_q.push_back('{ch: e2, data: ram[m_prev_addr], due: cyc + LAT});
        m_last = e2;
      end
    end
  end

  logic [DATA_W-1:0] e_data1 = '0;
  logic [DATA_W-1:0] e_data2 = '0;

  // Monitor: pop and compare on every vld, check held data every cycle
  always @(negedge sys_clk_i) begin : p_monitor
    exp_t e;
    if (!sys_rst_i) begin
      check("reset_outputs",
            {bus.ch1_gnt_o, bus.ch2_gnt_o, bus.ch1_vld_o, bus.ch2_vld_o,
             bus.mem_en_o, bus.mem_addr_o, bus.ch1_data_o, bus.ch2_data_o}, '0);
      e_data1 = '0;
      e_data2 = '0;
    end else begin
      if (bus.ch1_vld_o || bus.ch2_vld_o) begin
        if (sb_q.size() == 0) begin
          check("unexpected_vld", {bus.ch1_vld_o, bus.ch2_vld_o}, 2'b00);
        end else begin
          e = sb_q.pop_front();
          check("ret_channel", {bus.ch1_vld_o, bus.ch2_vld_o}, e.ch ? 2'b01 : 2'b10);
          check("ret_cycle", cyc, e.due);
          if (e.ch) e_data2 = e.data;
          else      e_data1 = e.data;
        end
      end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        check("missing_vld", {bus.ch1_vld_o, bus.ch2_vld_o}, e.ch ? 2'b01 : 2'b10);
      end
      check("ch1_data", bus.ch1_data_o, e_data1);
      check("ch2_data", bus.ch2_data_o, e_data2);
    end
  end

  task automatic step();
    @(posedge sys_clk_i);
    #1;
  endtask

  initial begin
    bit a1, a2;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'(i + 1);
    ram[10'h123] = 12'hABC;

    bus.arb_en_i   = 1'b0;
    bus.ch1_req_i  = 1'b0;
    bus.ch2_req_i  = 1'b0;
    bus.ch1_addr_i = '0;
    bus.ch2_addr_i = '0;
    repeat (3) step();
    sys_rst_i = 1'b1;

    // Tie held 4 cycles: alternating grants
    bus.arb_en_i   = 1'b1;
    bus.ch1_req_i  = 1'b1;
    bus.ch1_addr_i = 10'h005;
    bus.ch2_req_i  = 1'b1;
    bus.ch2_addr_i = 10'h3FF;
    repeat (4) step();
    bus.ch1_req_i = 1'b0;
    bus.ch2_req_i = 1'b0;
    repeat (5) step();

    // Lone CH2 requester, back-to-back
    bus.ch2_req_i  = 1'b1;
    bus.ch2_addr_i = 10'h010;
    repeat (5) step();
    bus.ch2_req_i = 1'b0;
    repeat (5) step();

    // Single CH1 read returning 0xABC, then long idle hold
    bus.ch1_req_i  = 1'b1;
    bus.ch1_addr_i = 10'h123;
    step();
    bus.ch1_req_i = 1'b0;
    repeat (14) step();

    // Disabled with both requesting, then enable
    bus.arb_en_i   = 1'b0;
    bus.ch1_req_i  = 1'b1;
    bus.ch1_addr_i = 10'h0AA;
    bus.ch2_req_i  = 1'b1;
    bus.ch2_addr_i = 10'h155;
    repeat (4) step();
    bus.arb_en_i = 1'b1;
    repeat (3) step();
    bus.ch1_req_i = 1'b0;
    bus.ch2_req_i = 1'b0;
    repeat (5) step();

    // Reset one cycle after an accept: read is discarded
    bus.ch1_req_i  = 1'b1;
    bus.ch1_addr_i = 10'h200;
    step();
    bus.ch1_req_i = 1'b0;
    sys_rst_i     = 1'b0;
    repeat (2) step();
    sys_rst_i      = 1'b1;
    bus.ch1_req_i  = 1'b1;
    bus.ch1_addr_i = 10'h001;
    bus.ch2_req_i  = 1'b1;
    bus.ch2_addr_i = 10'h002;
    step();
    bus.ch1_req_i = 1'b0;
    bus.ch2_req_i = 1'b0;
    repeat (6) step();

    // Randomized requesters that hold until granted
    for (int n = 0; n < 1500; n++) begin
      @(negedge sys_clk_i);
      a1 = bus.ch1_req_i & bus.ch1_gnt_o;
      a2 = bus.ch2_req_i & bus.ch2_gnt_o;
      step();
      if (!bus.ch1_req_i || a1) begin
        bus.ch1_req_i  = ($urandom_range(0, 99) < 55);
        bus.ch1_addr_i = ADDR_W'($urandom);
      end
      if (!bus.ch2_req_i || a2) begin
        bus.ch2_req_i  = ($urandom_range(0, 99) < 55);
        bus.ch2_addr_i = ADDR_W'($urandom);
      end
      bus.arb_en_i = ($urandom_range(0, 99) < 85);
      sys_rst_i    = ($urandom_range(0, 299) != 0);
    end

    sys_rst_i     = 1'b1;
    bus.arb_en_i  = 1'b0;
    bus.ch1_req_i = 1'b0;
    bus.ch2_req_i = 1'b0;
    repeat (8) step();
    check("drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
